// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache. Hits return with one cycle of registered latency.
// Misses refill the whole line with sequential single-word memory reads. A flush invalidates every line.
module icache #(
  parameter int XLEN           = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_cpu_re,
  input  logic [XLEN-1:0] i_cpu_addr,
  output logic            o_cpu_ack,
  output logic [31:0]     o_cpu_data,
  input  logic            i_flush,
  output logic            o_mem_re,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic            i_mem_ack,
  input  logic [31:0]     i_mem_data
);
  localparam int OW  = $clog2(WORDS_PER_LINE);
  localparam int IW  = $clog2(LINES);
  localparam int TW  = XLEN - 2 - OW - IW;
  localparam int LAW = XLEN - 2 - OW;
  localparam logic [OW-1:0] LAST_WORD = OW'(WORDS_PER_LINE - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t           r_state, w_state_nxt;
  logic [LINES-1:0] r_valid;
  logic [TW-1:0]    r_tag  [LINES];
  logic [31:0]      r_data [LINES][WORDS_PER_LINE];
  logic [LAW-1:0]   r_line_addr;
  logic [OW-1:0]    r_word_cnt;
  logic             r_flush_pend;
  logic             r_cpu_ack;
  logic [31:0]      r_cpu_data;

  logic [OW-1:0]    w_off;
  logic [IW-1:0]    w_idx;
  logic [TW-1:0]    w_tag;
  logic [IW-1:0]    w_fill_idx;
  logic [TW-1:0]    w_fill_tag;
  logic             w_req, w_hit, w_hit_ack;
  logic             w_miss_start, w_word_we, w_last_ack;
  logic             w_unused_addr_lsbs;

  assign w_off              = i_cpu_addr[2 +: OW];
  assign w_idx              = i_cpu_addr[2+OW +: IW];
  assign w_tag              = i_cpu_addr[XLEN-1 -: TW];
  assign w_unused_addr_lsbs = ^i_cpu_addr[1:0];
  assign w_fill_idx         = r_line_addr[IW-1:0];
  assign w_fill_tag         = r_line_addr[LAW-1 -: TW];

  // No new lookup in the ack cycle, so a held request is not answered twice.
  assign w_req     = i_cpu_re & ~r_cpu_ack;
  assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_hit_ack = (r_state == IDLE) && w_req && w_hit;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    o_mem_re     = 1'b0;
    o_mem_addr   = '0;
    w_miss_start = 1'b0;
    w_word_we    = 1'b0;
    w_last_ack   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req && !w_hit) begin
          w_miss_start = 1'b1;
          w_state_nxt  = FILL;
        end
      end
      FILL: begin
        o_mem_re   = 1'b1;
        o_mem_addr = {r_line_addr, r_word_cnt, 2'b00};
        if (i_mem_ack) begin
          w_word_we = 1'b1;
          if (r_word_cnt == LAST_WORD) begin
            w_last_ack  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_line_addr  <= '0;
      r_word_cnt   <= '0;
      r_flush_pend <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_cpu_data   <= '0;
    end else begin
      r_cpu_ack <= w_hit_ack;
      if (w_hit_ack)
        r_cpu_data <= r_data[w_idx][w_off];
      if (w_miss_start) begin
        r_line_addr <= i_cpu_addr[XLEN-1 -: LAW];
        r_word_cnt  <= '0;
      end else if (w_word_we) begin
        r_word_cnt <= r_word_cnt + OW'(1);
      end
      // A flush seen mid-fill keeps the refilled line invalid.
      if (w_last_ack)
        r_flush_pend <= 1'b0;
      else if ((r_state == FILL) && i_flush)
        r_flush_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else begin
      // The victim line is dropped while its words are overwritten.
      if (w_miss_start)
        r_valid[w_idx] <= 1'b0;
      if (w_last_ack && !r_flush_pend)
        r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays have no reset; the valid bits alone guard them.
  always_ff @(posedge clk) begin
    if (w_word_we)
      r_data[w_fill_idx][r_word_cnt] <= i_mem_data;
    if (w_last_ack)
      r_tag[w_fill_idx] <= w_fill_tag;
  end

  assign o_cpu_ack  = r_cpu_ack;
  assign o_cpu_data = r_cpu_data;

endmodule

// File: tb/tb_icache.sv
// Testbench for icache. A memory model has configurable wait states, and scoreboard
// queues hold the expected memory addresses and fetch data.
module tb_icache;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_re = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic        cpu_ack, mem_re, mem_ack;
  logic [31:0] cpu_data, mem_addr, mem_data;

  logic [31:0] key = 32'hA5A5A5A5;
  int          wait_cycles = 0;
  int          mem_cnt = 0;
  int          passed = 0;
  int          total = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];

  always #5 clk = ~clk;

  icache #(.XLEN(32), .LINES(16), .WORDS_PER_LINE(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_cpu_re   (cpu_re),
    .i_cpu_addr (cpu_addr),
    .o_cpu_ack  (cpu_ack),
    .o_cpu_data (cpu_data),
    .i_flush    (flush),
    .o_mem_re   (mem_re),
    .o_mem_addr (mem_addr),
    .i_mem_ack  (mem_ack),
    .i_mem_data (mem_data)
  );

  // The memory acks once a request has been held for wait_cycles cycles.
  assign mem_ack  = mem_re && (mem_cnt >= wait_cycles);
  assign mem_data = mem_addr ^ key;
  always @(posedge clk) begin
    if (!mem_re || mem_ack) mem_cnt <= 0;
    else                    mem_cnt <= mem_cnt + 1;
  end

  // Scoreboard: mem_addr is checked on every request cycle and popped on ack.
  always @(negedge clk) begin
    if (reset_n && mem_re) begin
      total++;
      if (exp_addr.size() == 0)
        $display("FAIL mem_addr: unexpected read of %h", mem_addr);
      else if (mem_addr !== exp_addr[0])
        $display("FAIL mem_addr: got %h expected %h", mem_addr, exp_addr[0]);
      else
        passed++;
      if (mem_ack && exp_addr.size() != 0) void'(exp_addr.pop_front());
    end
    if (reset_n && cpu_ack) begin
      total++;
      if (exp_data.size() == 0)
        $display("FAIL cpu_data: unexpected ack with %h", cpu_data);
      else if (cpu_data !== exp_data[0])
        $display("FAIL cpu_data: got %h expected %h", cpu_data, exp_data[0]);
      else
        passed++;
      if (exp_data.size() != 0) void'(exp_data.pop_front());
    end
  end

  task automatic push_line(input logic [31:0] base);
    for (int k = 0; k < 4; k++) exp_addr.push_back(base + 32'(4 * k));
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
  endtask

  // The request is sampled in cycle n=0. lat is the cycle of cpu_ack, or -1 on timeout.
  task automatic fetch(input logic [31:0] a, input int flush_at,
                       output int lat, output int reads, output int first_mre);
    lat = -1; reads = 0; first_mre = -1;
    @(posedge clk); #1;
    cpu_re = 1'b1; cpu_addr = a;
    for (int n = 0; n < 200; n++) begin
      flush = (n == flush_at);
      @(negedge clk);
      if (mem_re && first_mre < 0) first_mre = n;
      if (mem_re && mem_ack) reads++;
      if (cpu_ack) begin lat = n; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    cpu_re = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (cpu_ack !== 1'b0) $display("FAIL rst_cpu_ack: got %b expected 0", cpu_ack); else passed++;
    total++; if (cpu_data !== 32'h0) $display("FAIL rst_cpu_data: got %h expected 0", cpu_data); else passed++;
    total++; if (mem_re !== 1'b0) $display("FAIL rst_mem_re: got %b expected 0", mem_re); else passed++;
    total++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); else passed++;
    @(negedge clk); reset_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (mem_re !== 1'b0) $display("FAIL idle_mem_re: got %b expected 0", mem_re); else passed++;
  endtask

  task automatic test_cold_miss();
    int lat, reads, fm;
    push_line(32'h100);
    exp_data.push_back(32'h100 ^ key);
    fetch(32'h100, -1, lat, reads, fm);
    total++; if (lat !== 6) $display("FAIL cold_lat: got %0d expected 6", lat); else passed++;
    total++; if (reads !== 4) $display("FAIL cold_reads: got %0d expected 4", reads); else passed++;
    total++; if (fm !== 1) $display("FAIL cold_first_mem_re: got %0d expected 1", fm); else passed++;
    exp_data.push_back(32'h108 ^ key);
    fetch(32'h108, -1, lat, reads, fm);
    total++; if (lat !== 1) $display("FAIL hit_lat: got %0d expected 1", lat); else passed++;
    total++; if (fm !== -1) $display("FAIL hit_mem_re: got cycle %0d expected none", fm); else passed++;
  endtask

  task automatic test_conflict();
    int lat, reads, fm;
    logic [31:0] seq [3];
    seq[0] = 32'h100; seq[1] = 32'h500; seq[2] = 32'h100;
    pulse_flush();
    for (int i = 0; i < 3; i++) begin
      push_line(seq[i]);
      exp_data.push_back(seq[i] ^ key);
      fetch(seq[i], -1, lat, reads, fm);
      total++; if (reads !== 4) $display("FAIL conflict_reads[%0d]: got %0d expected 4", i, reads); else passed++;
      total++; if (lat !== 6) $display("FAIL conflict_lat[%0d]: got %0d expected 6", i, lat); else passed++;
    end
  endtask

  task automatic test_wait_states();
    int lat, reads, fm;
    wait_cycles = 3;
    push_line(32'h40);
    exp_data.push_back(32'h40 ^ key);
    fetch(32'h40, -1, lat, reads, fm);
    total++; if (reads !== 4) $display("FAIL wait_reads: got %0d expected 4", reads); else passed++;
    total++; if (lat !== 18) $display("FAIL wait_lat: got %0d expected 18", lat); else passed++;
    wait_cycles = 0;
  endtask

  task automatic test_flush();
    int lat, reads, fm;
    push_line(32'h200);
    exp_data.push_back(32'h200 ^ key);
    fetch(32'h200, -1, lat, reads, fm);
    exp_data.push_back(32'h200 ^ key);
    fetch(32'h200, -1, lat, reads, fm);
    total++; if (reads !== 0) $display("FAIL flush_prehit_reads: got %0d expected 0", reads); else passed++;
    key = 32'h5A5A0F0F;
    pulse_flush();
    push_line(32'h200);
    exp_data.push_back(32'h200 ^ key);
    fetch(32'h200, -1, lat, reads, fm);
    total++; if (reads !== 4) $display("FAIL flush_refill_reads: got %0d expected 4", reads); else passed++;
    total++; if (lat !== 6) $display("FAIL flush_refill_lat: got %0d expected 6", lat); else passed++;
  endtask

  task automatic test_flush_with_hit();
    int lat, reads, fm;
    exp_data.push_back(32'h200 ^ key);
    fetch(32'h200, 0, lat, reads, fm);
    total++; if (lat !== 1) $display("FAIL flush_hit_lat: got %0d expected 1", lat); else passed++;
    push_line(32'h200);
    exp_data.push_back(32'h200 ^ key);
    fetch(32'h200, -1, lat, reads, fm);
    total++; if (reads !== 4) $display("FAIL flush_hit_after_reads: got %0d expected 4", reads); else passed++;
  endtask

  task automatic test_flush_during_fill();
    int lat, reads, fm;
    push_line(32'h300);
    push_line(32'h300);
    exp_data.push_back(32'h300 ^ key);
    fetch(32'h300, 2, lat, reads, fm);
    total++; if (reads !== 8) $display("FAIL fill_flush_reads: got %0d expected 8", reads); else passed++;
    total++; if (lat !== 11) $display("FAIL fill_flush_lat: got %0d expected 11", lat); else passed++;
  endtask

  task automatic test_reset_mid_fill();
    int lat, reads, fm;
    int acks = 0;
    push_line(32'h340);
    @(posedge clk); #1;
    cpu_re = 1'b1; cpu_addr = 32'h340;
    for (int n = 0; n < 50 && acks < 2; n++) begin
      @(negedge clk);
      if (mem_re && mem_ack) acks++;
    end
    total++; if (acks !== 2) $display("FAIL rmf_acks: got %0d expected 2", acks); else passed++;
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    total++; if (mem_re !== 1'b0) $display("FAIL rmf_mem_re: got %b expected 0", mem_re); else passed++;
    total++; if (mem_addr !== 32'h0) $display("FAIL rmf_mem_addr: got %h expected 0", mem_addr); else passed++;
    cpu_re = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    push_line(32'h300);
    exp_data.push_back(32'h300 ^ key);
    fetch(32'h300, -1, lat, reads, fm);
    total++; if (reads !== 4) $display("FAIL rmf_refill_reads: got %0d expected 4", reads); else passed++;
    total++; if (lat !== 6) $display("FAIL rmf_refill_lat: got %0d expected 6", lat); else passed++;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_conflict();
    test_wait_states();
    test_flush();
    test_flush_with_hit();
    test_flush_during_fill();
    test_reset_mid_fill();
    repeat (3) @(negedge clk);
    total++; if (exp_addr.size() !== 0) $display("FAIL addr_queue_left: got %0d expected 0", exp_addr.size()); else passed++;
    total++; if (exp_data.size() !== 0) $display("FAIL data_queue_left: got %0d expected 0", exp_data.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the core's instruction fetch port and the shared memory read port. It answers fetch hits with one-cycle registered latency. On a miss it refills a whole line from memory with sequential single-word reads. A flush input invalidates every line; it is pulsed by fence.i and by self-modifying-code maintenance.

## Interface
- XLEN, 32, address width; data path fixed at 32 bits
- LINES, 16, number of cache lines; power of two, ≥2
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, ≥2

- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- cpu_re  in  1  fetch request; held high with stable cpu_addr until cpu_ack
- cpu_addr  in  XLEN  fetch byte address; bits [1:0] ignored
- cpu_ack  out  1  one-cycle pulse; cpu_data valid in the same cycle
- cpu_data  out  32  fetched instruction word
- flush  in  1  one-cycle pulse; invalidate all lines
- mem_re  out  1  memory read request; held with stable mem_addr until mem_ack
- mem_addr  out  XLEN  word-aligned memory address; bits [1:0] always 0
- mem_ack  in  1  read complete; mem_data valid this cycle; ignored while mem_re=0
- mem_data  in  32  memory read data

## Operation
- Address split:
  - offset = addr[2 +: log2(WORDS_PER_LINE)]
  - index = next log2(LINES) bits
  - tag = remaining upper bits
- Storage: per line, a valid bit, a tag and WORDS_PER_LINE data words, all in flops. Valid bits are cleared by reset. Tag and data are not reset.
- FSM states: IDLE, FILL.
- IDLE:
  - A request is sampled when cpu_re=1 and cpu_ack=0 this cycle.
  - Hit (valid and tag match): cpu_ack=1 and cpu_data=word next cycle; stay in IDLE.
  - Miss: latch the line base address (offset zeroed), enter FILL next cycle.
- FILL:
  - mem_re=1, mem_addr = base + 4·k for k = 0..WORDS_PER_LINE-1.
  - On each mem_ack, write mem_data into word k and advance k at that edge.
  - mem_re stays high across words, so the next word is requested the cycle after the ack.
  - On the last mem_ack: write the tag, set valid (unless the flush-pending flag is set), drop mem_re, return to IDLE.
  - The still-pending cpu request is then re-looked-up as a normal IDLE request.
- Flush:
  - Accepted in any state. Clears every valid bit at the next edge.
  - If it arrives during FILL, a flush-pending flag is set. The refilled line is written but left invalid, so the pending fetch misses again and refills.
  - The flag clears on return to IDLE.
- Simultaneous flush and hit lookup in IDLE: the lookup uses the pre-flush valid bits, so the hit is acked. The flush takes effect for later requests.
- cpu_re dropped mid-fill, which is illegal for the core: the fill completes and no ack is issued.

## Timing
- Reset values:
  - cpu_ack=0, cpu_data=0, mem_re=0, mem_addr=0
  - FSM=IDLE, all valid bits=0, flush-pending flag=0
- Async reset mid-FILL: mem_re drops immediately and the fill is abandoned. The memory side must tolerate the abandoned request.
- Hit latency: request sampled in cycle t, cpu_ack in t+1. No new sample in the ack cycle, so back-to-back hits run at one per 2 cycles.
- Miss latency:
  - Request sampled in cycle t; FILL entered and mem_re asserted in t+1.
  - With the last mem_ack in cycle N: IDLE lookup in N+1, cpu_ack in N+2.
  - With zero-wait memory (mem_ack the same cycle as mem_re), WORDS_PER_LINE=4 gives cpu_ack at t+6.
- Memory wait states stretch each word individually; mem_addr does not change until its mem_ack.

## Test plan
- Cold miss, zero-wait memory with mem_data=addr^0xA5A5A5A5, fetch 0x100:
  - mem_addr sequence 0x100, 0x104, 0x108, 0x10C in cycles t+1..t+4.
  - cpu_ack at t+6 with cpu_data=0xA5A5A4A5.
  - Then fetch 0x108 → ack at t'+1 and no mem_re.
- Conflict miss, LINES=16 and WORDS_PER_LINE=4: fetch 0x100, then 0x500 (same index, new tag), then 0x100 → three line fills, each returning correct data.
- Wait states: memory acks 3 cycles after each mem_re, fetch 0x40 → mem_addr holds each word until its ack; cpu_ack 2 cycles after the 4th ack.
- Flush: fill line at 0x200 and confirm a hit, pulse flush, fetch 0x200 → refill observed on the mem port.
- Flush during FILL: flush at the 2nd word of the fill for 0x300 → the fill completes, a second full refill of 0x300 follows, then cpu_ack.
- Reset mid-FILL after the 2nd word: mem_re=0 immediately. After reset, fetch 0x300 → full 4-word refill (line not valid).
